if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter IMEM_WORDS, default 32, instruction memory depth in 32-bit words.
REQ-003 Port clock, input, 1, sole clock; all state updates on posedge.
REQ-004 Port reset, input, 1, synchronous, active-high reset.
REQ-005 Port stall, input, 1, hold request from the hazard unit (load-use RAW).
REQ-006 Port branch_taken, input, 1, redirect request from decode/execute.
REQ-007 Port branch_target, input, 32, redirect byte address.
REQ-008 Port imem_addr, output, 10, word index to the combinational instruction memory; equals PC[11:2].
REQ-009 Port imem_rdata, input, 32, instruction word read at imem_addr in the same cycle.
REQ-010 Port PC, output, 32, current fetch address register.
REQ-011 Port instr, output, 32, instruction fetched this cycle; imem_rdata in RUN, 0 in HALT.
REQ-012 Port IFID_instr, output, 32, IF/ID pipeline register instruction.
REQ-013 Port IFID_pc4, output, 32, IF/ID pipeline register PC+4.
REQ-014 Port IFID_valid, output, 1, IF/ID register holds a real fetched instruction (not a bubble).
REQ-015 Port halted, output, 1, high while the state machine is in HALT.

Function
REQ-016 The block SHALL implement two states, RUN and HALT.
REQ-017 Event priority per posedge SHALL be: reset > branch_taken > stall > normal advance.
REQ-018 Normal advance in RUN SHALL do PC <= PC+4, IFID_instr <= imem_rdata, IFID_pc4 <= PC+4, IFID_valid <= 1.
REQ-019 PC+4 SHALL wrap modulo 2^32 with no overflow flag.
REQ-020 Stall, without branch_taken, SHALL hold PC, IFID_instr, IFID_pc4, IFID_valid and state unchanged.
REQ-021 branch_taken SHALL load PC <= {branch_target[31:2],2'b00} and clear IF/ID (IFID_instr=0, IFID_pc4=0, IFID_valid=0), whether or not stall is asserted.
REQ-022 The fetch-to-IFID latency SHALL be one cycle: the word at PC appears on IFID_instr after the next posedge.
REQ-023 RUN SHALL transition to HALT when the next PC (advance or redirect) is >= 4*IMEM_WORDS.
REQ-024 The instruction loaded into IF/ID on the RUN->HALT transition edge SHALL be the last in-range word; fetch has no partial behaviour.
REQ-025 In HALT, instr SHALL be 0; PC SHALL hold; normal advance SHALL load IF/ID with 0 and IFID_valid=0 (the bubble drains downstream).
REQ-026 In HALT, branch_taken with an in-range target SHALL redirect PC and return to RUN; an out-of-range target SHALL stay in HALT with PC updated.
REQ-027 halted SHALL be a registered flag equal to (state==HALT).
REQ-028 imem_addr SHALL be PC[11:2] in all states, with no gating by stall or halt.

Reset
REQ-029 On reset the block SHALL set PC=RESET_PC, IFID_instr=0, IFID_pc4=0, IFID_valid=0 and state=RUN, so halted=0.
REQ-030 Reset asserted mid-operation (including during stall, branch or HALT) SHALL take effect on that posedge and discard all in-flight state.
REQ-031 If RESET_PC >= 4*IMEM_WORDS, state SHALL still reset to RUN and enter HALT on the first edge after reset.

Verification
REQ-032 Straight line: reset 4 cycles, release, mem[0..2]=A,B,C -> PC 0,4,8 on successive cycles; IFID_instr A then B; IFID_pc4 4 then 8; IFID_valid=1.
REQ-033 Load-use stall: stall=1 for one cycle at PC=40 -> PC stays 40 for 2 samples; IFID_instr/IFID_pc4 unchanged; PC=44 on the next edge.
REQ-034 Redirect: branch_taken=1, branch_target=0x43 at PC=20 -> PC=0x40 next; IFID_instr=0 and IFID_valid=0 for one cycle; mem[16] enters IF/ID on the following edge.
REQ-035 Simultaneous stall and branch_taken with target 0x08 -> PC=8 and IF/ID cleared (branch wins).
REQ-036 Halt: IMEM_WORDS=32, run to PC=124 -> after the next edge PC=128, halted=1, instr=0; one more edge -> IFID_valid=0; branch_taken to 0 -> RUN, PC=0.
REQ-037 Reset mid-run at PC=60 with stall=1 -> PC=0, IFID_instr=0, IFID_valid=0, halted=0 after that edge.

Source files
------------

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, RUN/HALT control and the IF/ID
// pipeline register. The instruction memory is external and combinational.
module if_stage #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          IMEM_WORDS = 32
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic [9:0]  imem_addr,
   input  logic [31:0] imem_rdata,
   output logic [31:0] PC,
   output logic [31:0] instr,
   output logic [31:0] IFID_instr,
   output logic [31:0] IFID_pc4,
   output logic        IFID_valid,
   output logic        halted
);

   typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_t;

   // First byte address past the end of instruction memory.
   localparam logic [31:0] PC_LIMIT = 32'(4 * IMEM_WORDS);

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_ifid_instr;
   logic [31:0] r_ifid_pc4;
   logic        r_ifid_valid;
   logic        r_halted;

   logic [31:0] w_pc4;
   logic [31:0] w_target;
   logic        w_pc_oob;

   assign w_pc4    = r_pc + 32'd4;                 // wraps mod 2^32
   assign w_target = {branch_target[31:2], 2'b00};
   // Only reachable in RUN when RESET_PC itself lies beyond memory.
   assign w_pc_oob = (r_pc >= PC_LIMIT);

   assign imem_addr  = r_pc[11:2];
   assign PC         = r_pc;
   assign instr      = (r_state == S_RUN) ? imem_rdata : 32'd0;
   assign IFID_instr = r_ifid_instr;
   assign IFID_pc4   = r_ifid_pc4;
   assign IFID_valid = r_ifid_valid;
   assign halted     = r_halted;

   // Fetch FSM: reset > branch redirect > stall hold > normal advance.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state      <= S_RUN;
         r_halted     <= 1'b0;
         r_pc         <= RESET_PC;
         r_ifid_instr <= 32'd0;
         r_ifid_pc4   <= 32'd0;
         r_ifid_valid <= 1'b0;
      end else if (branch_taken) begin
         // Redirect flushes IF/ID; an out-of-range target parks us in HALT.
         r_pc         <= w_target;
         r_ifid_instr <= 32'd0;
         r_ifid_pc4   <= 32'd0;
         r_ifid_valid <= 1'b0;
         if (w_target >= PC_LIMIT) begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
         end else begin
            r_state  <= S_RUN;
            r_halted <= 1'b0;
         end
      end else if (!stall) begin
         case (r_state)
            S_RUN: begin
               if (w_pc_oob) begin
                  // Never fetch a word that does not exist: bubble and halt.
                  r_state      <= S_HALT;
                  r_halted     <= 1'b1;
                  r_ifid_instr <= 32'd0;
                  r_ifid_pc4   <= 32'd0;
                  r_ifid_valid <= 1'b0;
               end else begin
                  r_pc         <= w_pc4;
                  r_ifid_instr <= imem_rdata;
                  r_ifid_pc4   <= w_pc4;
                  r_ifid_valid <= 1'b1;
                  if (w_pc4 >= PC_LIMIT) begin
                     r_state  <= S_HALT;
                     r_halted <= 1'b1;
                  end
               end
            end
            default: begin
               // HALT: PC holds, bubbles drain through IF/ID.
               r_ifid_instr <= 32'd0;
               r_ifid_pc4   <= 32'd0;
               r_ifid_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: straight-line fetch, stall, redirect,
// halt/resume, mid-run reset and an out-of-range RESET_PC instance.
module tb_if_stage;

   logic        clock = 1'b0;
   logic        reset, stall, branch_taken;
   logic [31:0] branch_target;
   logic [9:0]  imem_addr;
   logic [31:0] imem_rdata;
   logic [31:0] PC, instr, IFID_instr, IFID_pc4;
   logic        IFID_valid, halted;

   // second instance: RESET_PC beyond memory
   logic [9:0]  b_imem_addr;
   logic [31:0] b_PC, b_instr, b_IFID_instr, b_IFID_pc4;
   logic        b_IFID_valid, b_halted;

   logic [31:0] mem [0:1023];
   int n_checks = 0;
   int n_errors = 0;

   always #5 clock = ~clock;

   assign imem_rdata = mem[imem_addr];

   if_stage #(.RESET_PC(32'h0), .IMEM_WORDS(32)) dut (
      .clock(clock), .reset(reset), .stall(stall), .branch_taken(branch_taken),
      .branch_target(branch_target), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .PC(PC), .instr(instr), .IFID_instr(IFID_instr), .IFID_pc4(IFID_pc4),
      .IFID_valid(IFID_valid), .halted(halted));

   if_stage #(.RESET_PC(32'h80), .IMEM_WORDS(32)) dut_oob (
      .clock(clock), .reset(reset), .stall(1'b0), .branch_taken(1'b0),
      .branch_target(32'h0), .imem_addr(b_imem_addr), .imem_rdata(32'hFFFF_FFFF),
      .PC(b_PC), .instr(b_instr), .IFID_instr(b_IFID_instr), .IFID_pc4(b_IFID_pc4),
      .IFID_valid(b_IFID_valid), .halted(b_halted));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // advance one edge and settle away from it
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++)
         mem[i] = (i < 32) ? (32'hC0DE_0000 | 32'(i)) : (32'hDEAD_0000 | 32'(i));
      reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
      repeat (4) tick();

      // reset state
      chk("rst_pc",     PC,         32'h0);
      chk("rst_ifid",   IFID_instr, 32'h0);
      chk("rst_pc4",    IFID_pc4,   32'h0);
      chk("rst_valid",  32'(IFID_valid), 32'h0);
      chk("rst_halted", 32'(halted), 32'h0);
      chk("rst_instr",  instr,      32'hC0DE_0000);
      chk("oob_rst_halted", 32'(b_halted), 32'h0);
      chk("oob_rst_pc", b_PC,       32'h80);
      reset = 1'b0;

      // straight line
      tick();
      chk("sl_pc1",    PC,         32'h4);
      chk("sl_ifid1",  IFID_instr, 32'hC0DE_0000);
      chk("sl_pc4_1",  IFID_pc4,   32'h4);
      chk("sl_valid1", 32'(IFID_valid), 32'h1);
      chk("oob_halted", 32'(b_halted), 32'h1);
      chk("oob_valid",  32'(b_IFID_valid), 32'h0);
      tick();
      chk("sl_pc2",    PC,         32'h8);
      chk("sl_ifid2",  IFID_instr, 32'hC0DE_0001);
      chk("sl_pc4_2",  IFID_pc4,   32'h8);
      chk("sl_instr",  instr,      32'hC0DE_0002);

      // load-use stall at PC=40
      repeat (8) tick();
      chk("st_pc0",   PC,         32'd40);
      chk("st_ifid0", IFID_instr, 32'hC0DE_0009);
      stall = 1'b1;
      tick();
      stall = 1'b0;
      chk("st_pc1",   PC,         32'd40);
      chk("st_ifid1", IFID_instr, 32'hC0DE_0009);
      chk("st_pc4_1", IFID_pc4,   32'd40);
      tick();
      chk("st_pc2",   PC,         32'd44);
      chk("st_ifid2", IFID_instr, 32'hC0DE_000A);
      chk("st_pc4_2", IFID_pc4,   32'd44);

      // redirect to 20, then 0x43 -> 0x40
      branch_taken = 1'b1; branch_target = 32'd20;
      tick();
      chk("br20_pc",    PC, 32'd20);
      chk("br20_valid", 32'(IFID_valid), 32'h0);
      branch_target = 32'h43;
      tick();
      branch_taken = 1'b0;
      chk("br_pc",    PC,         32'h40);
      chk("br_ifid",  IFID_instr, 32'h0);
      chk("br_valid", 32'(IFID_valid), 32'h0);
      chk("br_addr",  32'(imem_addr), 32'd16);
      tick();
      chk("br_next_ifid",  IFID_instr, 32'hC0DE_0010);
      chk("br_next_pc4",   IFID_pc4,   32'h44);
      chk("br_next_valid", 32'(IFID_valid), 32'h1);
      chk("br_next_pc",    PC,         32'h44);

      // stall and branch together: branch wins
      stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h8;
      tick();
      stall = 1'b0; branch_taken = 1'b0;
      chk("sb_pc",    PC,         32'h8);
      chk("sb_ifid",  IFID_instr, 32'h0);
      chk("sb_pc4",   IFID_pc4,   32'h0);
      chk("sb_valid", 32'(IFID_valid), 32'h0);

      // halt at end of memory
      branch_taken = 1'b1; branch_target = 32'd124;
      tick();
      branch_taken = 1'b0;
      chk("h_pc124",  PC, 32'd124);
      chk("h_run",    32'(halted), 32'h0);
      tick();
      chk("h_pc",     PC,         32'd128);
      chk("h_halted", 32'(halted), 32'h1);
      chk("h_instr",  instr,      32'h0);
      chk("h_ifid",   IFID_instr, 32'hC0DE_001F);
      chk("h_pc4",    IFID_pc4,   32'd128);
      chk("h_valid",  32'(IFID_valid), 32'h1);
      tick();
      chk("h2_pc",    PC,         32'd128);
      chk("h2_valid", 32'(IFID_valid), 32'h0);
      chk("h2_ifid",  IFID_instr, 32'h0);
      chk("h2_halted", 32'(halted), 32'h1);
      stall = 1'b1;
      tick();
      stall = 1'b0;
      chk("hs_halted", 32'(halted), 32'h1);
      chk("hs_pc",     PC, 32'd128);
      branch_taken = 1'b1; branch_target = 32'h200;
      tick();
      chk("hoob_pc",     PC, 32'h200);
      chk("hoob_halted", 32'(halted), 32'h1);
      chk("hoob_addr",   32'(imem_addr), 32'h80);
      chk("hoob_instr",  instr, 32'h0);
      branch_target = 32'h0;
      tick();
      branch_taken = 1'b0;
      chk("hres_pc",     PC, 32'h0);
      chk("hres_halted", 32'(halted), 32'h0);
      chk("hres_instr",  instr, 32'hC0DE_0000);

      // reset mid-run at PC=60 with stall
      repeat (15) tick();
      chk("mr_pc60", PC, 32'd60);
      stall = 1'b1; reset = 1'b1;
      tick();
      stall = 1'b0; reset = 1'b0;
      chk("mr_pc",     PC,         32'h0);
      chk("mr_ifid",   IFID_instr, 32'h0);
      chk("mr_valid",  32'(IFID_valid), 32'h0);
      chk("mr_halted", 32'(halted), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
